// File: rtl/ifetch_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_pkg
// Shared definitions for the instruction fetch stage.
//   IF_ADDR_W   : default fetch address / PC width
//   IF_INSTR_W  : default instruction word width
//   HALT_OPCODE : all-ones instruction that stops fetch when the build
//                 defines IFETCH_HALT_EN
//   fetch_entry_t : one buffered instruction tagged with its PC
// ----------------------------------------------------------------------------
package ifetch_pkg;

    localparam int IF_ADDR_W  = 4;
    localparam int IF_INSTR_W = 8;

    localparam logic [IF_INSTR_W-1:0] HALT_OPCODE = {IF_INSTR_W{1'b1}};

    typedef struct packed {
        logic [IF_ADDR_W-1:0]  pc;
        logic [IF_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
// Two-entry FIFO of fetch_entry_t. slot0 is always the head, so the head
// output comes straight from a register. Push and pop may coincide at any
// occupancy; flush empties the queue.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data this cycle
//   push_data  : entry to write
//   pop        : remove the head this cycle (only when count != 0)
//   flush      : discard all entries (dominates push/pop)
//   head       : current head entry
//   count      : occupancy 0..2
// ifetch_queue_chk (same file) holds the overflow/underflow assertions.
// ----------------------------------------------------------------------------
module ifetch_queue
    import ifetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t slot0_r;
    fetch_entry_t slot1_r;
    logic [1:0]   count_r;

    // Queue storage and occupancy update.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_r <= '0;
            slot1_r <= '0;
            count_r <= 2'd0;
        end else if (flush) begin
            count_r <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        slot0_r <= push_data;
                    end else begin
                        slot1_r <= push_data;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    slot0_r <= slot1_r;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new entry lands behind the
                    // surviving one (or becomes the head if none survives).
                    if (count_r == 2'd2) begin
                        slot0_r <= slot1_r;
                        slot1_r <= push_data;
                    end else begin
                        slot0_r <= push_data;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign head  = slot0_r;
    assign count = count_r;

    ifetch_queue_chk u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .count (count_r)
    );

endmodule

// Assertions on queue usage: the issue rule upstream must keep the
// queue from overflowing, and pop is only legal with a valid head.
module ifetch_queue_chk (
    input logic       clk,
    input logic       rst,
    input logic       push,
    input logic       pop,
    input logic       flush,
    input logic [1:0] count
);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !flush && (count == 2'd2)));

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && (count == 2'd0)));

endmodule

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
// Fetch stage: issues sequential reads to a 1-cycle-latency instruction ROM,
// buffers {pc, instr} in a 2-entry queue and hands them to the decoder over
// valid/ready. A redirect flushes queued and in-flight work and restarts
// fetch at redirect_addr.
// Optional build macro IFETCH_HALT_EN: an all-ones instruction is still
// delivered but stops further fetch until redirect or rst.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   redirect            : restart fetch at redirect_addr (flushes stage)
//   redirect_addr       : new fetch address
//   mem_req, mem_addr   : ROM read strobe and address
//   mem_rdata           : ROM data, valid one cycle after mem_req
//   out_valid, out_ready: decoder handshake
//   out_instr, out_pc   : head instruction and its PC
// ----------------------------------------------------------------------------
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int ADDR_W  = IF_ADDR_W,
    parameter int INSTR_W = IF_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] req_pc_r;
    logic              inflight_r;
    logic              halted_r;

    logic [1:0]   count_s;
    fetch_entry_t head_s;
    fetch_entry_t push_data_s;
    logic         pop_s;
    logic         push_s;
    logic         halt_hit_s;
    logic         issue_s;
    logic [2:0]   occ_s;

    // Handshake, response capture and issue decision.
    always_comb begin
        pop_s  = (count_s != 2'd0) & out_ready;
        // A response landing in a redirect cycle belongs to the old stream.
        push_s = inflight_r & ~redirect & ~rst;
        push_data_s.pc    = req_pc_r;
        push_data_s.instr = mem_rdata;
        // Slots committed after this edge: queued + in flight - leaving.
        occ_s = {1'b0, count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
`ifdef IFETCH_HALT_EN
        // Stop issuing in the same cycle the HALT arrives, so nothing past
        // it is ever fetched.
        halt_hit_s = push_s & (mem_rdata == HALT_OPCODE);
`else
        halt_hit_s = 1'b0;
`endif
        issue_s = ~rst & ~redirect & ~halted_r & ~halt_hit_s & (occ_s < 3'd2);
    end

    // Fetch PC, in-flight tracking and halt state.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= '0;
            req_pc_r   <= '0;
            inflight_r <= 1'b0;
            halted_r   <= 1'b0;
        end else if (redirect) begin
            fetch_pc_r <= redirect_addr;
            inflight_r <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            if (issue_s) begin
                fetch_pc_r <= fetch_pc_r + ADDR_W'(1);
                req_pc_r   <= fetch_pc_r;
                inflight_r <= 1'b1;
            end else begin
                inflight_r <= 1'b0;
            end
            if (halt_hit_s) begin
                halted_r <= 1'b1;
            end else begin
                halted_r <= halted_r;
            end
        end
    end

    ifetch_queue u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .flush     (redirect),
        .head      (head_s),
        .count     (count_s)
    );

    assign mem_req   = issue_s;
    assign mem_addr  = fetch_pc_r;
    assign out_valid = (count_s != 2'd0);
    assign out_instr = head_s.instr;
    assign out_pc    = head_s.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch. A ROM model answers reads one cycle
// later; each test pushes the {pc, instr} stream it expects the decoder to
// see into a scoreboard queue, and a monitor pops and compares on every
// handshake. Tests also check cycle-exact timing inline.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       redirect;
    logic [3:0] redirect_addr;
    logic       mem_req;
    logic [3:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_instr;
    logic [3:0] out_pc;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [11:0] exp_q[$];
    logic [11:0] mon_exp;
    logic [7:0]  rom [16];

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc)
    );

    // ROM model: 1-cycle read latency, junk when not read.
    always @(posedge clk) begin
        if (mem_req === 1'b1) mem_rdata <= rom[mem_addr];
        else                  mem_rdata <= 8'h5A;
    end

    // Scoreboard monitor: every transfer must match the next expected entry.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got pc=%0d instr=%h, required no transfer", out_pc, out_instr);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({out_pc, out_instr} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL sb_data: got pc=%0d instr=%h, required pc=%0d instr=%h",
                             out_pc, out_instr, mon_exp[11:8], mon_exp[7:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int pc);
        logic [3:0] p;
        p = 4'(pc);
        exp_q.push_back({p, rom[p]});
    endtask

    // Leaves the bench at the start of cycle 0 after reset release.
    task automatic do_reset(input logic rdy);
        out_ready = 1'b0;
        rst = 1'b1;
        redirect = 1'b0;
        redirect_addr = 4'd0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        out_ready = rdy;
        exp_q.delete();
    endtask

    task automatic check_empty(input string name);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing: %0d expected transfers never seen, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        redirect = 1'b0;
        redirect_addr = 4'd0;
        rst = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_tests++;
        if ({out_valid, out_pc, out_instr, mem_req} !== {1'b0, 4'd0, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b pc=%0d instr=%h req=%b, required 0 0 00 0",
                     out_valid, out_pc, out_instr, mem_req);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({mem_req, mem_addr} !== {1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_first_req: got req=%b addr=%0d, required 1 0", mem_req, mem_addr);
        end
        next_cycle();
    endtask

    task automatic test_free_run();
        do_reset(1'b1);
        for (int i = 0; i < 20; i++) push_exp(i);
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== (c >= 2)) begin
                n_fail++;
                $display("FAIL free_valid c%0d: got %b, required %b", c, out_valid, (c >= 2));
            end
            n_tests++;
            if ({mem_req, mem_addr} !== {1'b1, 4'(c)}) begin
                n_fail++;
                $display("FAIL free_req c%0d: got req=%b addr=%0d, required 1 %0d", c, mem_req, mem_addr, c % 16);
            end
            next_cycle();
        end
        out_ready = 1'b0;
        check_empty("free");
    endtask

    task automatic test_backpressure();
        int reqs;
        reqs = 0;
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) push_exp(i);
        for (int c = 0; c < 12; c++) begin
            if (c == 8) out_ready = 1'b1;
            @(negedge clk);
            if (mem_req === 1'b1) reqs++;
            if (c >= 2 && c < 8) begin
                n_tests++;
                if ({out_valid, mem_req, out_pc, out_instr} !== {1'b1, 1'b0, 4'd0, rom[0]}) begin
                    n_fail++;
                    $display("FAIL bp_hold c%0d: got valid=%b req=%b pc=%0d instr=%h, required 1 0 0 %h",
                             c, out_valid, mem_req, out_pc, out_instr, rom[0]);
                end
            end
            if (c == 7) begin
                n_tests++;
                if (reqs != 2) begin
                    n_fail++;
                    $display("FAIL bp_outstanding: got %0d requests, required 2", reqs);
                end
            end
            if (c >= 8) begin
                n_tests++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_stream c%0d: got valid=%b, required 1", c, out_valid);
                end
            end
            next_cycle();
        end
        out_ready = 1'b0;
        check_empty("bp");
    endtask

    task automatic test_redirect_stream();
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) push_exp(i);
        for (int i = 9; i < 12; i++) push_exp(i);
        for (int c = 0; c < 12; c++) begin
            redirect = (c == 6);
            redirect_addr = 4'd9;
            @(negedge clk);
            if (c == 6) begin
                n_tests++;
                if (mem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL redir_req_blocked: got req=%b, required 0", mem_req);
                end
            end
            if (c == 7) begin
                n_tests++;
                if ({mem_req, mem_addr} !== {1'b1, 4'd9}) begin
                    n_fail++;
                    $display("FAIL redir_first_req: got req=%b addr=%0d, required 1 9", mem_req, mem_addr);
                end
            end
            if (c >= 7) begin
                n_tests++;
                if (out_valid !== (c >= 9)) begin
                    n_fail++;
                    $display("FAIL redir_valid c%0d: got %b, required %b", c, out_valid, (c >= 9));
                end
            end
            next_cycle();
        end
        out_ready = 1'b0;
        check_empty("redir");
    endtask

    task automatic test_redirect_full();
        do_reset(1'b0);
        for (int i = 2; i < 5; i++) push_exp(i);
        for (int c = 0; c < 11; c++) begin
            redirect = (c == 5);
            redirect_addr = 4'd2;
            out_ready = (c >= 6);
            @(negedge clk);
            if (c == 5) begin
                n_tests++;
                if ({out_valid, out_pc, mem_req} !== {1'b1, 4'd0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL full_before: got valid=%b pc=%0d req=%b, required 1 0 0", out_valid, out_pc, mem_req);
                end
            end
            if (c >= 6 && c <= 8) begin
                n_tests++;
                if ({out_valid, (c == 8) ? out_pc : 4'd2} !== {(c == 8), 4'd2}) begin
                    n_fail++;
                    $display("FAIL full_after c%0d: got valid=%b pc=%0d, required %b 2", c, out_valid, out_pc, (c == 8));
                end
            end
            next_cycle();
        end
        out_ready = 1'b0;
        check_empty("full");
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) push_exp(i);
        push_exp(12);
        push_exp(13);
        for (int c = 0; c < 10; c++) begin
            redirect = (c == 4) || (c == 5);
            redirect_addr = (c == 4) ? 4'd7 : 4'd12;
            @(negedge clk);
            if (c == 4 || c == 5) begin
                n_tests++;
                if (mem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_req_blocked c%0d: got req=%b, required 0", c, mem_req);
                end
            end
            if (c == 6) begin
                n_tests++;
                if ({mem_req, mem_addr} !== {1'b1, 4'd12}) begin
                    n_fail++;
                    $display("FAIL b2b_last_wins: got req=%b addr=%0d, required 1 12", mem_req, mem_addr);
                end
            end
            if (c >= 5) begin
                n_tests++;
                if (out_valid !== (c >= 8)) begin
                    n_fail++;
                    $display("FAIL b2b_valid c%0d: got %b, required %b", c, out_valid, (c >= 8));
                end
            end
            next_cycle();
        end
        out_ready = 1'b0;
        check_empty("b2b");
    endtask

    task automatic test_rst_mid();
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) push_exp(i);
        push_exp(0);
        push_exp(1);
        for (int c = 0; c < 10; c++) begin
            rst = (c == 5);
            out_ready = (c != 5);
            @(negedge clk);
            if (c == 5) begin
                n_tests++;
                if (mem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rstmid_req: got req=%b during rst, required 0", mem_req);
                end
            end
            if (c == 6) begin
                n_tests++;
                if ({out_valid, out_instr, out_pc, mem_req, mem_addr} !== {1'b0, 8'd0, 4'd0, 1'b1, 4'd0}) begin
                    n_fail++;
                    $display("FAIL rstmid_after: got valid=%b instr=%h pc=%0d req=%b addr=%0d, required 0 00 0 1 0",
                             out_valid, out_instr, out_pc, mem_req, mem_addr);
                end
            end
            if (c >= 7) begin
                n_tests++;
                if (out_valid !== (c >= 8)) begin
                    n_fail++;
                    $display("FAIL rstmid_valid c%0d: got %b, required %b", c, out_valid, (c >= 8));
                end
            end
            next_cycle();
        end
        out_ready = 1'b0;
        check_empty("rstmid");
    endtask

    task automatic test_halt();
        rom[3] = 8'hFF;
        do_reset(1'b1);
`ifdef IFETCH_HALT_EN
        for (int i = 0; i < 4; i++) push_exp(i);
        push_exp(5);
        push_exp(6);
        for (int c = 0; c < 31; c++) begin
            redirect = (c == 26);
            redirect_addr = 4'd5;
            @(negedge clk);
            if (c >= 4 && c <= 25) begin
                n_tests++;
                if ({mem_req, out_valid} !== {1'b0, (c <= 5)}) begin
                    n_fail++;
                    $display("FAIL halt_stopped c%0d: got req=%b valid=%b, required 0 %b", c, mem_req, out_valid, (c <= 5));
                end
            end
            if (c == 27) begin
                n_tests++;
                if ({mem_req, mem_addr} !== {1'b1, 4'd5}) begin
                    n_fail++;
                    $display("FAIL halt_resume: got req=%b addr=%0d, required 1 5", mem_req, mem_addr);
                end
            end
            next_cycle();
        end
`else
        for (int i = 0; i < 8; i++) push_exp(i);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== (c >= 2)) begin
                n_fail++;
                $display("FAIL nohalt_valid c%0d: got %b, required %b", c, out_valid, (c >= 2));
            end
            if (c == 6) begin
                n_tests++;
                if (out_pc !== 4'd4) begin
                    n_fail++;
                    $display("FAIL nohalt_continue: got pc=%0d, required 4", out_pc);
                end
            end
            next_cycle();
        end
`endif
        out_ready = 1'b0;
        redirect = 1'b0;
        check_empty("halt");
        rom[3] = 8'd9;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'(3 * i);
        rst = 1'b1;
        redirect = 1'b0;
        redirect_addr = 4'd0;
        out_ready = 1'b0;
        test_reset();
        test_free_run();
        test_backpressure();
        test_redirect_stream();
        test_redirect_full();
        test_back_to_back();
        test_rst_mid();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage that generates sequential fetch addresses and issues reads to a synchronous instruction ROM with 1-cycle read latency. It buffers returned instructions, tagged with their PC, in a 2-entry queue and presents them to the decoder over a valid/ready handshake. A branch/jump redirect flushes all buffered and in-flight work and restarts fetch at the new address.

Parameters:
ADDR_W, 4, fetch address / PC width in bits
INSTR_W, 8, instruction word width in bits

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
redirect  input  1  restart fetch at redirect_addr; flushes the stage
redirect_addr  input  ADDR_W  new fetch address, sampled when redirect=1
mem_req  output  1  ROM read strobe; the ROM always accepts
mem_addr  output  ADDR_W  ROM read address; valid when mem_req=1
mem_rdata  input  INSTR_W  ROM data; valid exactly 1 cycle after mem_req
out_valid  output  1  head of queue holds a valid instruction
out_ready  input  1  decoder accepts the head this cycle
out_instr  output  INSTR_W  instruction at head of queue
out_pc  output  ADDR_W  PC of out_instr

Behaviour:
- Reset (rst=1 at an edge): fetch_pc=0, inflight=0, queue empty, halted=0. Outputs: out_valid=0, out_instr=0, out_pc=0, mem_req=0. Reset mid-operation discards all queue entries and any in-flight response.
- Handshake: transfer occurs when out_valid&out_ready. out_instr and out_pc are stable while out_valid=1 and out_ready=0.
- pop = out_valid&out_ready.
- Issue rule: mem_req = !rst_state & !redirect & !halted & (count + inflight - pop < 2). count is queue occupancy (0..2); inflight is a 1-bit flag.
- On issue: mem_addr=fetch_pc. fetch_pc <= fetch_pc+1 modulo 2^ADDR_W, so 2^ADDR_W-1 wraps to 0. inflight <= 1, and req_pc_q <= fetch_pc.
- Response: if inflight=1, mem_rdata is pushed as {req_pc_q, mem_rdata}. inflight clears unless a new request issues in the same cycle.
- Latency: request in cycle t, queue write at end of t+1, out_valid=1 in t+2. After reset release, the first out_valid appears 2 cycles after the first mem_req.
- Throughput: 1 instruction per cycle with out_ready held at 1.
- Queue: 2-entry FIFO, registered storage, head drives the outputs. Simultaneous push and pop are legal at any occupancy. The issue rule makes overflow impossible; the implementation must include an assertion for this.
- Redirect in cycle t:
  - mem_req=0 in t; fetch_pc <= redirect_addr.
  - A response arriving in t is discarded; all queue entries are cleared at the t edge; inflight <= 0; halted <= 0.
  - out_valid is not masked in t. A handshake completing in t is a valid transfer; the decoder is responsible for squashing it.
  - First request goes to redirect_addr in t+1, so out_valid=1 with out_pc=redirect_addr in t+3.
- Back-to-back redirects: the last one wins; no request issues while redirect=1.
- rst has priority over redirect.

Optional Feature:
IFETCH_HALT_EN
- Defined: a pushed instruction equal to all ones (HALT_OPCODE) sets halted=1. The HALT itself is still queued and delivered. No further mem_req issues until redirect or rst; both clear halted.
- Undefined: all-ones is an ordinary instruction, halted is tied to 0, and fetch continues sequentially.

Decomposition:
- Package ifetch_pkg holds:
  - default ADDR_W and INSTR_W;
  - HALT_OPCODE = all ones;
  - typedef fetch_entry_t = struct {pc[ADDR_W], instr[INSTR_W]}.
- Sub-module ifetch_queue: 2-entry FIFO of fetch_entry_t with push, pop, flush, count, head outputs.
- Top module: fetch_pc, inflight and req_pc_q registers, issue logic, halt logic.

Test Plan:
- Free run: ROM[i]=3*i mod 256, out_ready=1. out_pc 0,1,2,… one per cycle starting 2 cycles after the first mem_req; out_instr=3*pc; after pc 15 the next out_pc is 0.
- Backpressure: out_ready=0 for 6 cycles from the first out_valid. Exactly 2 requests are outstanding, mem_req=0 while stalled, and the head holds pc0. After release, pcs 0,1,2,3 arrive contiguously with no loss or duplicate.
- Redirect to 9 while streaming, asserted in cycle t. The response arriving in t is dropped. Next out_valid is in t+3 with out_pc=9, followed by 10, 11.
- Redirect with the queue full and out_ready=0, redirect_addr=2. out_valid=0 in t+1 and t+2; out_pc=2 in t+3; stale entries never appear.
- rst pulse mid-stream. Next cycle out_valid=0, out_instr=0, out_pc=0; fetch restarts at address 0 with the same 2-cycle latency.
- IFETCH_HALT_EN defined, ROM[3]=8'hFF: pcs 0–3 delivered, then mem_req stays 0 and out_valid stays 0 for 20 cycles; redirect to 5 resumes at pc 5. Without the macro, delivery continues with pc 4.
